// File: rtl/apb_wait_slave_if.sv
// APB3 bus bundle between the team's APB master and apb_wait_slave.
// wait_cycles rides along with the bus because the master drives it alongside setup.
interface apb_wait_slave_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [3:0]            wait_cycles;
    logic                  pready;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, wait_cycles,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, wait_cycles,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_wait_slave.sv
// APB3 completer with register-file memory, programmable wait states and
// two read-only status words (0x10 = SLAVE_ID, 0x11 = committed write count).
module apb_wait_slave #(
    parameter int          ADDR_WIDTH = 8,
    parameter int          DATA_WIDTH = 16,
    parameter int          DEPTH      = 2**ADDR_WIDTH,
    parameter logic [15:0] SLAVE_ID   = 16'h5A01
) (
    input logic              pclk,
    input logic              preset,
    apb_wait_slave_if.slave  bus
);
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ID  = ADDR_WIDTH'(8'h10);
    localparam logic [ADDR_WIDTH-1:0] ADDR_CNT = ADDR_WIDTH'(8'h11);

    logic [0:0]            state;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  pready_q;
    logic                  pslverr_q;
    logic [DATA_WIDTH-1:0] prdata_q;
    logic [DATA_WIDTH-1:0] wr_count;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // A zero-wait transfer resolves at the setup edge, before the address is
    // latched, so decode looks at the live bus while idle.
    logic [ADDR_WIDTH-1:0] dec_addr;
    logic                  dec_write;
    logic                  is_id, is_cnt, unmapped, err;
    logic [DATA_WIDTH-1:0] rd_val;

    always_comb begin
        dec_addr  = (state == ST_IDLE) ? bus.paddr  : addr_q;
        dec_write = (state == ST_IDLE) ? bus.pwrite : write_q;
        is_id     = (dec_addr == ADDR_ID);
        is_cnt    = (dec_addr == ADDR_CNT);
        unmapped  = (32'(dec_addr) >= DEPTH);
        err       = dec_write ? (is_id | is_cnt | unmapped) : unmapped;
        rd_val    = '0;
        if (is_id)
            rd_val = DATA_WIDTH'(SLAVE_ID);
        else if (is_cnt)
            rd_val = wr_count;
        else if (!unmapped)
            rd_val = mem[dec_addr];
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            pready_q  <= 1'b1;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            wr_count  <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    pready_q  <= 1'b1;
                    pslverr_q <= 1'b0;
                    if (bus.psel && !bus.penable) begin
                        addr_q  <= bus.paddr;
                        write_q <= bus.pwrite;
                        wdata_q <= bus.pwdata;
                        cnt     <= bus.wait_cycles;
                        state   <= ST_ACCESS;
                        if (bus.wait_cycles == 4'd0) begin
                            pslverr_q <= err;
                            if (!bus.pwrite)
                                prdata_q <= rd_val;
                        end else begin
                            pready_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    if (!bus.psel) begin
                        // master abandoned the transfer: nothing commits
                        state     <= ST_IDLE;
                        cnt       <= '0;
                        pready_q  <= 1'b1;
                        pslverr_q <= 1'b0;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            pready_q  <= 1'b1;
                            pslverr_q <= err;
                            if (!write_q)
                                prdata_q <= rd_val;
                        end
                    end else begin
                        state     <= ST_IDLE;
                        pslverr_q <= 1'b0;
                        if (bus.penable && pready_q && write_q && !err) begin
                            mem[addr_q] <= wdata_q;
                            wr_count    <= wr_count + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.pready  = pready_q;
    assign bus.pslverr = pslverr_q;
    assign bus.prdata  = prdata_q;
endmodule

// File: tb/tb_apb_wait_slave.sv
// Directed bench for apb_wait_slave: hand-computed vectors covering reset,
// wait states, protected addresses, abort and mid-transfer reset.
module tb_apb_wait_slave;
    logic pclk = 1'b0;
    logic preset;
    int   total = 0;
    int   bad   = 0;

    apb_wait_slave_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus ();

    apb_wait_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic xfer(input bit wr, input logic [7:0] a, input logic [15:0] d,
                        input logic [3:0] n, output logic [15:0] rd, output logic err,
                        output int wcyc, output logic err_after);
        bit done;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
        bus.paddr = a;   bus.pwdata = d;     bus.wait_cycles = n;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        bus.wait_cycles = 4'hF;
        wcyc = 0; done = 1'b0; rd = 'x; err = 'x;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge pclk);
            if (bus.pready === 1'b1) begin
                rd = bus.prdata; err = bus.pslverr; done = 1'b1;
            end else begin
                wcyc++;
            end
            @(posedge pclk); #1;
        end
        chk("xfer_done", 32'(done), 32'd1);
        bus.psel = 1'b0; bus.penable = 1'b0;
        @(negedge pclk);
        err_after = bus.pslverr;
        @(posedge pclk); #1;
    endtask

    logic [15:0] rd;
    logic        err, err_after;
    int          wc;

    initial begin
        preset = 1'b1;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = '0;  bus.pwdata = '0;    bus.wait_cycles = '0;
        repeat (2) @(posedge pclk);
        #1 preset = 1'b0;
        @(negedge pclk);
        chk("rst_pready",  32'(bus.pready),  32'd1);
        chk("rst_pslverr", 32'(bus.pslverr), 32'd0);
        chk("rst_prdata",  32'(bus.prdata),  32'h0);
        @(posedge pclk); #1;

        xfer(0, 8'h05, 16'h0, 4'd0, rd, err, wc, err_after);
        chk("rd05_data", 32'(rd), 32'h0);
        chk("rd05_err",  32'(err), 32'd0);
        chk("rd05_wait", 32'(wc), 32'd0);

        xfer(1, 8'h20, 16'hA5A5, 4'd0, rd, err, wc, err_after);
        chk("wr20_err",  32'(err), 32'd0);
        chk("wr20_wait", 32'(wc), 32'd0);
        xfer(0, 8'h20, 16'h0, 4'd0, rd, err, wc, err_after);
        chk("rd20_data", 32'(rd), 32'hA5A5);
        chk("rd20_wait", 32'(wc), 32'd0);
        xfer(0, 8'h11, 16'h0, 4'd0, rd, err, wc, err_after);
        chk("cnt_1", 32'(rd), 32'h1);

        xfer(0, 8'h20, 16'h0, 4'd3, rd, err, wc, err_after);
        chk("n3_wait", 32'(wc), 32'd3);
        chk("n3_data", 32'(rd), 32'hA5A5);
        chk("n3_err",  32'(err), 32'd0);
        xfer(0, 8'h05, 16'h0, 4'd0, rd, err, wc, err_after);
        chk("n0_wait", 32'(wc), 32'd0);
        chk("n0_data", 32'(rd), 32'h0);

        xfer(1, 8'h10, 16'h1234, 4'd0, rd, err, wc, err_after);
        chk("wr10_err",   32'(err), 32'd1);
        chk("wr10_after", 32'(err_after), 32'd0);
        xfer(0, 8'h10, 16'h0, 4'd0, rd, err, wc, err_after);
        chk("id_data", 32'(rd), 32'h5A01);
        xfer(0, 8'h11, 16'h0, 4'd0, rd, err, wc, err_after);
        chk("cnt_still1", 32'(rd), 32'h1);
        xfer(1, 8'h11, 16'hFFFF, 4'd2, rd, err, wc, err_after);
        chk("wr11_err",  32'(err), 32'd1);
        chk("wr11_wait", 32'(wc), 32'd2);
        chk("wr_keeps_prdata", 32'(bus.prdata), 32'h1);
        xfer(0, 8'h11, 16'h0, 4'd0, rd, err, wc, err_after);
        chk("cnt_after_err", 32'(rd), 32'h1);

        // abort: drop psel after two wait cycles
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 8'h30; bus.pwdata = 16'hBEEF; bus.wait_cycles = 4'd5;
        @(posedge pclk); #1 bus.penable = 1'b1;
        @(negedge pclk);
        chk("abort_wait", 32'(bus.pready), 32'd0);
        @(posedge pclk); #1;
        @(posedge pclk); #1 bus.psel = 1'b0; bus.penable = 1'b0;
        @(posedge pclk);
        @(negedge pclk);
        chk("abort_pready",  32'(bus.pready),  32'd1);
        chk("abort_pslverr", 32'(bus.pslverr), 32'd0);
        @(posedge pclk); #1;
        xfer(0, 8'h30, 16'h0, 4'd0, rd, err, wc, err_after);
        chk("abort_mem", 32'(rd), 32'h0);
        xfer(0, 8'h11, 16'h0, 4'd0, rd, err, wc, err_after);
        chk("abort_cnt", 32'(rd), 32'h1);

        xfer(1, 8'h21, 16'h1357, 4'd2, rd, err, wc, err_after);
        chk("wr21_wait", 32'(wc), 32'd2);
        xfer(0, 8'h21, 16'h0, 4'd1, rd, err, wc, err_after);
        chk("rd21_data", 32'(rd), 32'h1357);
        chk("rd21_wait", 32'(wc), 32'd1);
        xfer(0, 8'h11, 16'h0, 4'd0, rd, err, wc, err_after);
        chk("cnt_2", 32'(rd), 32'h2);

        // reset during the second wait cycle of a write
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 8'h40; bus.pwdata = 16'h1111; bus.wait_cycles = 4'd4;
        @(posedge pclk); #1 bus.penable = 1'b1;
        @(posedge pclk); #1 preset = 1'b1;
        @(posedge pclk); #1 preset = 1'b0; bus.psel = 1'b0; bus.penable = 1'b0;
        @(negedge pclk);
        chk("mrst_pready",  32'(bus.pready),  32'd1);
        chk("mrst_pslverr", 32'(bus.pslverr), 32'd0);
        chk("mrst_prdata",  32'(bus.prdata),  32'h0);
        @(posedge pclk); #1;
        xfer(0, 8'h40, 16'h0, 4'd0, rd, err, wc, err_after);
        chk("mrst_mem40", 32'(rd), 32'h0);
        xfer(0, 8'h11, 16'h0, 4'd0, rd, err, wc, err_after);
        chk("mrst_cnt", 32'(rd), 32'h0);
        xfer(0, 8'h20, 16'h0, 4'd0, rd, err, wc, err_after);
        chk("mrst_mem20", 32'(rd), 32'h0);

        // penable without a setup phase must be ignored
        bus.psel = 1'b1; bus.penable = 1'b1; bus.pwrite = 1'b1;
        bus.paddr = 8'h22; bus.pwdata = 16'h7777; bus.wait_cycles = 4'd0;
        repeat (2) @(posedge pclk);
        #1 bus.psel = 1'b0; bus.penable = 1'b0;
        @(posedge pclk); #1;
        xfer(0, 8'h22, 16'h0, 4'd0, rd, err, wc, err_after);
        chk("viol_mem", 32'(rd), 32'h0);
        xfer(0, 8'h11, 16'h0, 4'd0, rd, err, wc, err_after);
        chk("viol_cnt", 32'(rd), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
